// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: loads a cipher key, then streams round keys 0..10
// over a valid/ready handshake with one next-key computation per accepted transfer.
module aes_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t       state, state_nxt;
  logic [7:0]   rcon, rcon_nxt;
  logic         key_acc, rk_acc, last_acc;
  logic [31:0]  w0, w1, w2, w3, rot, t;
  logic [31:0]  n0, n1, n2, n3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs decode straight from state so a reset drops rk_valid without a clock edge.
  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    key_acc   = 1'b0;
    rk_acc    = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          key_acc   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          rk_acc = 1'b1;
          if (rk_round == 4'd10) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_acc = rk_acc && (rk_round == 4'd10);

  assign {w0, w1, w2, w3} = rk_out;
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
             ^ {rcon, 24'h0};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out   <= '0;
      rk_round <= '0;
      rcon     <= 8'h01;
      done     <= 1'b0;
    end else begin
      done <= last_acc;
      if (key_acc) begin
        rk_out   <= key_in;
        rk_round <= '0;
        rcon     <= 8'h01;
      end else if (rk_acc && !last_acc) begin
        rk_out   <= {n0, n1, n2, n3};
        rk_round <= rk_round + 4'd1;
        rcon     <= rcon_nxt;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 round-key tables plus backpressure,
// back-to-back key and mid-stream reset sequences.
module tb_aes_key_sched;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  aes_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .done      (done)
  );

  typedef struct {
    logic [3:0]   round;
    logic [127:0] exp;
  } rk_vec_t;

  rk_vec_t vecs [22];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Loads vecs[first].exp as key with rk_ready high and checks all 11 round keys back to back.
  task automatic run_stream(input int first);
    int d0;
    @(negedge clk);
    chk("idle_key_ready", key_ready, 1);
    d0        = done_cnt;
    key_valid = 1'b1;
    key_in    = vecs[first].exp;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("stream_valid", rk_valid, 1);
      chk("stream_round", rk_round, vecs[first+i].round);
      chk("stream_rk",    rk_out,   vecs[first+i].exp);
      @(negedge clk);
    end
    chk("done_pulse",      done,      1);
    chk("done_rk_valid",   rk_valid,  0);
    chk("done_key_ready",  key_ready, 1);
    chk("done_hold_round", rk_round,  10);
    chk("done_hold_rk",    rk_out,    vecs[first+10].exp);
    @(negedge clk);
    chk("done_one_cycle",  done, 0);
    chk("done_count",      done_cnt - d0, 1);
  endtask

  initial begin
    logic [127:0] k0, k1;
    bit seen, early_ready;

    vecs[0]  = '{4'd0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[1]  = '{4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[2]  = '{4'd2,  128'hb692cf0b643dbdf1be9bc5006830b3fe};
    vecs[3]  = '{4'd3,  128'hb6ff744ed2c2c9bf6c590cbf0469bf41};
    vecs[4]  = '{4'd4,  128'h47f7f7bc95353e03f96c32bcfd058dfd};
    vecs[5]  = '{4'd5,  128'h3caaa3e8a99f9deb50f3af57adf622aa};
    vecs[6]  = '{4'd6,  128'h5e390f7df7a69296a7553dc10aa31f6b};
    vecs[7]  = '{4'd7,  128'h14f9701ae35fe28c440adf4d4ea9c026};
    vecs[8]  = '{4'd8,  128'h47438735a41c65b9e016baf4aebf7ad2};
    vecs[9]  = '{4'd9,  128'h549932d1f08557681093ed9cbe2c974e};
    vecs[10] = '{4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[11] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[12] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[13] = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[14] = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[15] = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[16] = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[17] = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[18] = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[19] = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[20] = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[21] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    k0 = vecs[0].exp;
    k1 = vecs[11].exp;

    rst       = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_rk_valid",  rk_valid,  0);
    chk("rst_rk_out",    rk_out,    0);
    chk("rst_rk_round",  rk_round,  0);
    chk("rst_done",      done,      0);
    @(negedge clk);
    rst = 1'b0;

    run_stream(0);
    run_stream(11);

    // Backpressure at round 3.
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = k0;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("bp_round_before", rk_round, 3);
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_round", rk_round, 3);
      chk("bp_hold_rk",    rk_out,   vecs[3].exp);
      chk("bp_hold_valid", rk_valid, 1);
    end
    rk_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_round", rk_round, 4);
    chk("bp_resume_rk",    rk_out,   vecs[4].exp);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("bp_drain_done", seen, 1);

    // Back-to-back keys: second key held valid throughout the first stream.
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = k0;
    @(negedge clk);
    key_in = k1;
    chk("b2b_first_rk0", rk_out, k0);
    seen        = 1'b0;
    early_ready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (key_ready) early_ready = 1'b1;
    end
    chk("b2b_done_seen",     seen,        1);
    chk("b2b_ready_in_emit", early_ready, 0);
    chk("b2b_ready_at_done", key_ready,   1);
    chk("b2b_first_rk10",    rk_out,      vecs[10].exp);
    @(negedge clk);
    key_valid = 1'b0;
    chk("b2b_second_valid", rk_valid, 1);
    chk("b2b_second_round", rk_round, 0);
    chk("b2b_second_rk0",   rk_out,   k1);
    @(negedge clk);
    chk("b2b_second_rk1",   rk_out,   vecs[12].exp);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("b2b_drain_done", seen, 1);

    // Reset asserted between edges at round 5.
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = k0;
    @(negedge clk);
    key_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rk_valid && rk_round == 4'd5) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid_reached_r5", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rk_valid",  rk_valid,  0);
    chk("rst_mid_key_ready", key_ready, 1);
    chk("rst_mid_rk_round",  rk_round,  0);
    chk("rst_mid_rk_out",    rk_out,    0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_no_rk", rk_valid, 0);
    run_stream(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
